// File: rtl/alu_seq_unit.sv
// alu_seq_unit: single-issue ALU with a valid/ready request and response handshake.
// Operations: ADD, SUB, AND, SLL, SRL. Codes 101-111 are illegal and return an error.
// Non-zero shifts run one bit per cycle through the SHIFT state.
// Optional build macro ALU_SEQ_FAST_SHIFT_EN: when defined, shifts use a
// combinational barrel shifter and complete with the same latency as ADD.
// The SHIFT state is then never entered. Results are identical in both builds.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_SLL = 3'b011,
    OP_SRL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q;      // working value while shifting iteratively
  logic [SHW-1:0]   cnt_q;      // remaining single-bit shift steps
  logic             dir_right_q;

  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             is_illegal;
  logic             shift_iter;
  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] acc_next;

  // Only the low log2(WIDTH) bits of B form the shift amount. Upper bits are ignored.
  assign shamt      = req_b[SHW-1:0];
  assign is_shift   = (req_op == OP_SLL) || (req_op == OP_SRL);
  assign is_illegal = (req_op > OP_SRL);

`ifdef ALU_SEQ_FAST_SHIFT_EN
  assign shift_iter = 1'b0;
`else
  assign shift_iter = is_shift && (shamt != '0);
`endif

  // Single-cycle result for every operation that skips the SHIFT state.
  always_comb begin
    // NOTE: a default value precedes the case, so no path leaves quick_res unassigned and no latch is inferred.
    quick_res = '0;
    case (req_op)
      OP_ADD: quick_res = req_a + req_b;
      OP_SUB: quick_res = req_a - req_b;
      OP_AND: quick_res = req_a & req_b;
`ifdef ALU_SEQ_FAST_SHIFT_EN
      OP_SLL: quick_res = req_a << shamt;
      OP_SRL: quick_res = req_a >> shamt;
`else
      // Reached only for a shift by zero. A non-zero shift goes through SHIFT.
      OP_SLL: quick_res = req_a;
      OP_SRL: quick_res = req_a;
`endif
      default: quick_res = '0;
    endcase
  end

  // Working value after one more single-bit step.
  assign acc_next = dir_right_q ? (acc_q >> 1) : (acc_q << 1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic. SHIFT exits on the step that takes the counter to zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = shift_iter ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);

  // Datapath registers. Operands are captured on accept. The response is held until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      rsp_out     <= '0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rsp_err <= is_illegal;
            if (shift_iter) begin
              acc_q       <= req_a;
              cnt_q       <= shamt;
              dir_right_q <= (req_op == OP_SRL);
            end else begin
              rsp_out  <= quick_res;
              rsp_zero <= (quick_res == '0);
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            rsp_out  <= acc_next;
            rsp_zero <= (acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed testbench for alu_seq_unit (WIDTH = 32) with hand-computed expected values.
// Expected latencies follow the build: define ALU_SEQ_FAST_SHIFT_EN here too for the fast-shift build.
module tb_alu_seq_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_out;
  logic        rsp_zero;
  logic        rsp_err;

  int n_pass  = 0;
  int n_total = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Shift latency: n+1 cycles iteratively, or 1 cycle with the fast shifter.
  function automatic int shift_lat(input int n);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 1;
`else
    return (n == 0) ? 1 : n + 1;
`endif
  endfunction

  // Called at a negedge. Issues one request, measures latency, checks the response, then takes it.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] exp_out,
                       input logic exp_zero, input logic exp_err, input int exp_lat);
    int lat;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rsp_out"}, rsp_out, exp_out);
    check({tag, " rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " back to idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    #2;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_out",   rsp_out,        32'd0);
    check("reset rsp_zero",  32'(rsp_zero),  32'd0);
    check("reset rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // The first accept happens on the first rising edge after reset release.
    do_op("add",      32'h0000000F, 32'h00000004, 3'b000, 32'h00000013, 1'b0, 1'b0, 1);
    do_op("sub",      32'h0000000F, 32'h00000004, 3'b001, 32'h0000000B, 1'b0, 1'b0, 1);
    do_op("sub zero", 32'h00000004, 32'h00000004, 3'b001, 32'h00000000, 1'b1, 1'b0, 1);
    do_op("add wrap", 32'hFFFFFFFF, 32'h00000002, 3'b000, 32'h00000001, 1'b0, 1'b0, 1);
    do_op("and zero", 32'h00001111, 32'h00000004, 3'b010, 32'h00000000, 1'b1, 1'b0, 1);
    do_op("and",      32'hF0F0A5A5, 32'h0FF0FF00, 3'b010, 32'h00F0A500, 1'b0, 1'b0, 1);
    do_op("srl 1",    32'h80000000, 32'h00000001, 3'b100, 32'h40000000, 1'b0, 1'b0, shift_lat(1));
    do_op("sll 2",    32'h00000001, 32'h00000002, 3'b011, 32'h00000004, 1'b0, 1'b0, shift_lat(2));
    do_op("sll 0x22", 32'h00000001, 32'h00000022, 3'b011, 32'h00000004, 1'b0, 1'b0, shift_lat(2));
    do_op("sll 0",    32'h00001234, 32'h00000020, 3'b011, 32'h00001234, 1'b0, 1'b0, shift_lat(0));
    do_op("srl 31",   32'h80000000, 32'h0000001F, 3'b100, 32'h00000001, 1'b0, 1'b0, shift_lat(31));
    do_op("sll out",  32'h00000003, 32'h0000001F, 3'b011, 32'h80000000, 1'b0, 1'b0, shift_lat(31));

    // An illegal op holds its response while rsp_ready stays low. New requests are ignored meanwhile.
    req_a = 32'h12345678; req_b = 32'h1; req_op = 3'b111; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_a = 32'h00000005; req_b = 32'h00000003; req_op = 3'b000;
    for (int i = 0; i < 5; i++) begin
      check("hold rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold req_ready", 32'(req_ready), 32'd0);
      check("hold rsp_out",   rsp_out,        32'd0);
      check("hold rsp_err",   32'(rsp_err),   32'd1);
      check("hold rsp_zero",  32'(rsp_zero),  32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    // req_valid was high on the release edge, but no accept may happen on that edge.
    check("release req_ready", 32'(req_ready), 32'd1);
    check("release rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset mid-operation aborts the shift. No response for it may appear afterwards.
    req_a = 32'h00000001; req_b = 32'd20; req_op = 3'b011; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort rsp_out",   rsp_out,        32'd0);
    check("abort rsp_zero",  32'(rsp_zero),  32'd0);
    check("abort rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort no response", 32'(seen), 32'd0);
    do_op("add post", 32'h00000001, 32'h00000001, 3'b000, 32'h00000002, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, at least 8.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port req_valid  input  1  requester presents an operation.
REQ-005 Port req_ready  output  1  unit can accept an operation.
REQ-006 Port req_a  input  WIDTH  operand A.
REQ-007 Port req_b  input  WIDTH  operand B; shift amount = low log2(WIDTH) bits.
REQ-008 Port req_op  input  3  000 ADD, 001 SUB, 010 AND, 011 SLL, 100 SRL, 101-111 illegal.
REQ-009 Port rsp_valid  output  1  result available.
REQ-010 Port rsp_ready  input  1  consumer takes result.
REQ-011 Port rsp_out  output  WIDTH  result.
REQ-012 Port rsp_zero  output  1  rsp_out equals zero.
REQ-013 Port rsp_err  output  1  operation was illegal.

Function
REQ-014 The unit SHALL implement FSM states IDLE, SHIFT, DONE; req_ready SHALL be 1 only in IDLE, rsp_valid 1 only in DONE.
REQ-015 Accept SHALL occur on a clock edge with IDLE and req_valid=1; operands and op latched at that edge; inputs ignored otherwise.
REQ-016 ADD/SUB SHALL be modulo 2^WIDTH (no carry/borrow output); AND bitwise; SLL/SRL logical, zero-fill.
REQ-017 ADD, SUB, AND, illegal, and shifts by 0 SHALL go IDLE->DONE; rsp_valid asserted the cycle after accept (latency 1).
REQ-018 SLL/SRL by n>0 (iterative mode) SHALL go IDLE->SHIFT, shift one bit per cycle, load counter n, decrement per cycle, go SHIFT->DONE on the cycle count reaches 0; rsp_valid asserted n+1 cycles after accept.
REQ-019 Illegal op SHALL yield rsp_out=0, rsp_err=1, rsp_zero=1; legal ops SHALL yield rsp_err=0.
REQ-020 rsp_zero SHALL be 1 exactly when rsp_out is all zeros.
REQ-021 In DONE, rsp_out/rsp_zero/rsp_err SHALL stay stable until rsp_ready=1; on that edge FSM SHALL return to IDLE (no accept on the same edge).
REQ-022 rsp_ready SHALL be ignored outside DONE; req_valid dropping during SHIFT SHALL not affect the operation.
REQ-023 Shift amount bits of req_b above log2(WIDTH) SHALL be ignored.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_out=0, rsp_zero=0, rsp_err=0, counter=0.
REQ-025 Reset asserted in SHIFT or DONE SHALL abort the operation; no response for it is ever produced.
REQ-026 First accept after reset release SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-027 Macro ALU_SEQ_FAST_SHIFT_EN: when defined, SLL/SRL SHALL be computed combinationally and follow REQ-017 (latency 1), SHIFT state unreachable.
REQ-028 Without ALU_SEQ_FAST_SHIFT_EN, shifts SHALL follow REQ-018; results identical in both builds, only latency differs.

Verification
REQ-029 a=0x0000000F, b=0x00000004, op=000 -> rsp_out=0x00000013, zero=0, err=0, rsp_valid 1 cycle after accept.
REQ-030 same operands, op=001 -> 0x0000000B; a=b=0x00000004 op=001 -> 0x00000000, rsp_zero=1.
REQ-031 a=0x00001111, b=0x00000004, op=010 -> 0x00000000, rsp_zero=1; a=0x80000000, b=1, op=100 -> 0x40000000.
REQ-032 a=0x00000001, b=0x00000002, op=011 -> 0x00000004; rsp_valid 3 cycles after accept (1 with ALU_SEQ_FAST_SHIFT_EN); b=0x00000022 gives same result.
REQ-033 op=111 -> rsp_out=0, err=1; hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0, then rsp_ready=1 -> IDLE next cycle.
REQ-034 SLL by 20 with rst_n pulsed low in SHIFT -> outputs at reset values immediately, no rsp_valid; next ADD 1+1 -> 0x00000002.
